// File: rtl/axis_master_gen.sv
// AXI-Stream traffic master: emits a programmed number of packets with
// configurable length, tail keep, payload pattern and valid throttle.
module axis_master_gen #(
  parameter int unsigned DATA_WD      = 32,
  parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
  parameter int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
  parameter int unsigned LEN_WD       = 8,
  parameter int unsigned PKT_WD       = 16,
  parameter logic [31:0] LFSR_SEED    = 32'hACE1_2B3D
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    cfg_mode,
  input  logic [LEN_WD-1:0]       cfg_burst_len,
  input  logic [PKT_WD-1:0]       cfg_pkt_num,
  input  logic [BYTE_CNT_WD:0]    cfg_tail_bytes,
  input  logic [3:0]              cfg_throttle,
  output logic                    busy,
  output logic                    done,
  output logic [PKT_WD-1:0]       pkt_cnt,
  output logic                    valid_m,
  output logic [DATA_WD-1:0]      data_m,
  output logic [DATA_BYTE_WD-1:0] keep_m,
  output logic                    last_m,
  input  logic                    ready_m
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [15:0] THR_SEED = LFSR_SEED[15:0];

  state_t state, state_nxt;

  logic                 mode_q;
  logic [LEN_WD-1:0]    len_q;
  logic [PKT_WD-1:0]    pkt_num_q;
  logic [BYTE_CNT_WD:0] tail_q;
  logic [3:0]           thr_q;

  logic [LEN_WD-1:0]    beat_idx;
  logic [PKT_WD-1:0]    ld_pkt;
  logic [7:0]           byte_cnt;
  logic [31:0]          dlfsr;
  logic [15:0]          tlfsr;

  // Galois data LFSR, taps 32,22,2,1
  function automatic logic [31:0] dstep(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  // Fibonacci throttle LFSR, x^16+x^14+x^13+x^11+1
  function automatic logic [15:0] tstep(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // The beat loaded on the start cycle is built from the raw cfg inputs and
  // fresh run state; later beats use the latched copies.
  logic                 first, hs, slot, more, load, beat_last;
  logic                 src_mode;
  logic [LEN_WD-1:0]    src_len, src_idx;
  logic [PKT_WD-1:0]    src_pkt_num, src_ldpkt, pkt_cnt_inc;
  logic [BYTE_CNT_WD:0] src_tail;
  logic [3:0]           src_thr, thr_val;
  logic [7:0]           src_b;
  logic [31:0]          src_lfsr;

  assign first       = (state == IDLE) && start;
  assign hs          = valid_m && ready_m;
  assign pkt_cnt_inc = pkt_cnt + PKT_WD'(1);

  // Select the configuration / run-state sources feeding the beat builder
  always_comb begin
    src_mode    = first ? cfg_mode : mode_q;
    src_len     = first ? ((cfg_burst_len == '0) ? LEN_WD'(1) : cfg_burst_len) : len_q;
    src_pkt_num = first ? cfg_pkt_num : pkt_num_q;
    src_tail    = first ? cfg_tail_bytes : tail_q;
    src_thr     = first ? cfg_throttle : thr_q;
    src_idx     = first ? '0 : beat_idx;
    src_ldpkt   = first ? '0 : ld_pkt;
    src_b       = first ? '0 : byte_cnt;
    src_lfsr    = first ? LFSR_SEED : dlfsr;
    thr_val     = first ? THR_SEED[3:0] : tlfsr[3:0];
    slot        = first || ((state == RUN) && (!valid_m || hs));
    more        = (src_ldpkt != src_pkt_num);
    load        = slot && more && (thr_val <= src_thr);
    beat_last   = (src_idx == src_len - LEN_WD'(1));
  end

  logic [DATA_WD-1:0]      beat_data;
  logic [DATA_BYTE_WD-1:0] beat_keep;
  int unsigned             tail_n;

  // Build payload and keep for the beat that would be loaded this cycle
  always_comb begin
    beat_data = '0;
    beat_keep = '1;
    if (src_tail == '0)
      tail_n = (src_lfsr % DATA_BYTE_WD) + 1;
    else if (32'(src_tail) > DATA_BYTE_WD)
      tail_n = DATA_BYTE_WD;
    else
      tail_n = 32'(src_tail);
    if (src_mode) begin
      for (int unsigned j = 0; j < DATA_WD / 32; j++)
        beat_data[32*j +: 32] = src_lfsr ^ (32'(j) * 32'h9E37_79B9);
    end else begin
      for (int unsigned k = 0; k < DATA_BYTE_WD; k++)
        beat_data[DATA_WD-1-8*k -: 8] = src_b + 8'(k);
    end
    for (int unsigned k = 0; k < DATA_BYTE_WD; k++)
      beat_keep[DATA_BYTE_WD-1-k] = !beat_last || (k < tail_n);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and status outputs; a zero-packet run completes via
  // one RUN cycle with nothing pending, so done lands two cycles after start
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if ((hs && last_m && (pkt_cnt_inc == pkt_num_q)) ||
            ((pkt_num_q == '0) && !valid_m))
          state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Config latch, LFSRs, beat counters and registered AXIS outputs.
  // The start cycle consumes the seed as its throttle draw, so the throttle
  // LFSR continues from the seed's successor.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= 1'b0;
      len_q     <= '0;
      pkt_num_q <= '0;
      tail_q    <= '0;
      thr_q     <= '0;
      pkt_cnt   <= '0;
      beat_idx  <= '0;
      ld_pkt    <= '0;
      byte_cnt  <= '0;
      dlfsr     <= LFSR_SEED;
      tlfsr     <= THR_SEED;
      valid_m   <= 1'b0;
      data_m    <= '0;
      keep_m    <= '0;
      last_m    <= 1'b0;
    end else begin
      if (first) begin
        mode_q    <= cfg_mode;
        len_q     <= src_len;
        pkt_num_q <= cfg_pkt_num;
        tail_q    <= cfg_tail_bytes;
        thr_q     <= cfg_throttle;
        pkt_cnt   <= '0;
        tlfsr     <= tstep(THR_SEED);
      end else if (state == RUN) begin
        tlfsr <= tstep(tlfsr);
      end
      if (load) begin
        dlfsr    <= dstep(src_lfsr);
        byte_cnt <= src_b + 8'(DATA_BYTE_WD);
        ld_pkt   <= beat_last ? src_ldpkt + PKT_WD'(1) : src_ldpkt;
        beat_idx <= beat_last ? '0 : src_idx + LEN_WD'(1);
        valid_m  <= 1'b1;
        data_m   <= beat_data;
        keep_m   <= beat_keep;
        last_m   <= beat_last;
      end else begin
        if (first) begin
          dlfsr    <= LFSR_SEED;
          byte_cnt <= '0;
          ld_pkt   <= '0;
          beat_idx <= '0;
        end
        if (slot) valid_m <= 1'b0;
      end
      if ((state == RUN) && hs && last_m) pkt_cnt <= pkt_cnt_inc;
    end
  end

endmodule

// File: tb/tb_axis_master_gen.sv
// Directed self-checking bench for axis_master_gen (32-bit data).
module tb_axis_master_gen;

  logic        clk = 1'b0;
  logic        rst, start, cfg_mode, ready_m;
  logic [7:0]  cfg_burst_len;
  logic [15:0] cfg_pkt_num;
  logic [2:0]  cfg_tail_bytes;
  logic [3:0]  cfg_throttle;
  logic        busy, done, valid_m, last_m;
  logic [15:0] pkt_cnt;
  logic [31:0] data_m;
  logic [3:0]  keep_m;

  int checks = 0;
  int failures = 0;

  axis_master_gen #(
    .DATA_WD(32),
    .LEN_WD(8),
    .PKT_WD(16),
    .LFSR_SEED(32'hACE1_2B3D)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_mode(cfg_mode),
    .cfg_burst_len(cfg_burst_len), .cfg_pkt_num(cfg_pkt_num),
    .cfg_tail_bytes(cfg_tail_bytes), .cfg_throttle(cfg_throttle),
    .busy(busy), .done(done), .pkt_cnt(pkt_cnt),
    .valid_m(valid_m), .data_m(data_m), .keep_m(keep_m), .last_m(last_m),
    .ready_m(ready_m)
  );

  always #5 clk = ~clk;

  // Called at a negedge with the DUT idle; returns at the negedge after the
  // edge that sampled start (first beat visible here).
  task automatic kick(input logic m, input logic [7:0] len, input logic [15:0] pn,
                      input logic [2:0] tail, input logic [3:0] thr);
    cfg_mode = m; cfg_burst_len = len; cfg_pkt_num = pn;
    cfg_tail_bytes = tail; cfg_throttle = thr; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; ready_m = 1'b1;
    cfg_mode = 1'b0; cfg_burst_len = '0; cfg_pkt_num = '0;
    cfg_tail_bytes = '0; cfg_throttle = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++; if (valid_m !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", valid_m); end
    checks++; if (last_m !== 1'b0) begin failures++; $display("FAIL reset_last got=%0b exp=0", last_m); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
    checks++; if (data_m !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", data_m); end
    checks++; if (keep_m !== 4'h0) begin failures++; $display("FAIL reset_keep got=%b exp=0000", keep_m); end
    checks++; if (pkt_cnt !== 16'h0) begin failures++; $display("FAIL reset_pkt_cnt got=%0d exp=0", pkt_cnt); end
  endtask

  // Two 4-beat packets, full rate; optionally pokes start mid-run.
  task automatic test_basic(input bit poke);
    logic [31:0] ed [8];
    logic [3:0]  ek;
    logic        el;
    ed = '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F,
           32'h10111213, 32'h14151617, 32'h18191A1B, 32'h1C1D1E1F};
    kick(1'b0, 8'd4, 16'd2, 3'd3, 4'd15);
    for (int i = 0; i < 8; i++) begin
      el = (i == 3) || (i == 7);
      ek = el ? 4'b1110 : 4'b1111;
      checks++; if (valid_m !== 1'b1) begin failures++; $display("FAIL basic_valid beat=%0d got=%0b exp=1", i, valid_m); end
      checks++; if (data_m !== ed[i]) begin failures++; $display("FAIL basic_data beat=%0d got=%h exp=%h", i, data_m, ed[i]); end
      checks++; if (keep_m !== ek) begin failures++; $display("FAIL basic_keep beat=%0d got=%b exp=%b", i, keep_m, ek); end
      checks++; if (last_m !== el) begin failures++; $display("FAIL basic_last beat=%0d got=%0b exp=%0b", i, last_m, el); end
      if (poke && i == 4) begin start = 1'b1; cfg_pkt_num = 16'd1; cfg_mode = 1'b1; end
      if (poke && i == 5) begin start = 1'b0; cfg_pkt_num = 16'd2; cfg_mode = 1'b0; end
      @(negedge clk);
    end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL basic_done got=%0b exp=1", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_done got=%0b exp=0", busy); end
    checks++; if (valid_m !== 1'b0) begin failures++; $display("FAIL basic_valid_done got=%0b exp=0", valid_m); end
    checks++; if (pkt_cnt !== 16'd2) begin failures++; $display("FAIL basic_pkt_cnt got=%0d exp=2", pkt_cnt); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%0b exp=0", done); end
  endtask

  // Same run, ready_m held low for 5 cycles while beat 2 is offered.
  task automatic test_backpressure();
    logic [31:0] ed [8];
    logic [31:0] hd;
    logic [3:0]  hk;
    logic        hl;
    int got, stall, cyc;
    ed = '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F,
           32'h10111213, 32'h14151617, 32'h18191A1B, 32'h1C1D1E1F};
    got = 0; stall = 0; cyc = 0; hd = '0; hk = '0; hl = 1'b0;
    kick(1'b0, 8'd4, 16'd2, 3'd3, 4'd15);
    while (got < 8 && cyc < 40) begin
      if (valid_m) begin
        if (got == 2 && stall > 0) begin
          checks++; if (data_m !== hd || keep_m !== hk || last_m !== hl) begin
            failures++; $display("FAIL bp_hold stall=%0d got=%h/%b/%0b exp=%h/%b/%0b", stall, data_m, keep_m, last_m, hd, hk, hl);
          end
        end
        if (got == 2 && stall < 5) begin
          if (stall == 0) begin hd = data_m; hk = keep_m; hl = last_m; end
          ready_m = 1'b0; stall++;
        end else begin
          ready_m = 1'b1;
          checks++; if (data_m !== ed[got]) begin failures++; $display("FAIL bp_data beat=%0d got=%h exp=%h", got, data_m, ed[got]); end
          checks++; if (last_m !== (got == 3 || got == 7)) begin failures++; $display("FAIL bp_last beat=%0d got=%0b", got, last_m); end
          got++;
        end
      end else begin
        checks++; failures++;
        $display("FAIL bp_valid_gap beat=%0d got=0 exp=1", got);
        ready_m = 1'b1;
      end
      if (got < 8) @(negedge clk);
      cyc++;
    end
    checks++; if (got !== 8) begin failures++; $display("FAIL bp_beats got=%0d exp=8", got); end
    checks++; if (stall !== 5) begin failures++; $display("FAIL bp_stall got=%0d exp=5", stall); end
    @(negedge clk);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL bp_done got=%0b exp=1", done); end
    checks++; if (pkt_cnt !== 16'd2) begin failures++; $display("FAIL bp_pkt_cnt got=%0d exp=2", pkt_cnt); end
    @(negedge clk);
  endtask

  // throttle=3, 10 single-beat packets, random ready, oversized tail clamps.
  task automatic test_throttle();
    logic        pv, pr, pl;
    logic [31:0] pd, ex;
    logic [7:0]  b;
    int got, cyc;
    bit seen_done;
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0; got = 0; cyc = 0; seen_done = 0;
    kick(1'b0, 8'd1, 16'd10, 3'd7, 4'd3);
    while (!seen_done && cyc < 600) begin
      if (pv && !pr) begin
        checks++; if (valid_m !== 1'b1 || data_m !== pd || last_m !== pl) begin
          failures++; $display("FAIL thr_hold got=%0b/%h exp=1/%h", valid_m, data_m, pd);
        end
      end
      if (done) seen_done = 1;
      ready_m = ($urandom_range(0, 3) != 0);
      if (valid_m && ready_m) begin
        b = 8'(4 * got);
        ex = {b, b + 8'd1, b + 8'd2, b + 8'd3};
        checks++; if (data_m !== ex) begin failures++; $display("FAIL thr_data beat=%0d got=%h exp=%h", got, data_m, ex); end
        checks++; if (last_m !== 1'b1 || keep_m !== 4'b1111) begin
          failures++; $display("FAIL thr_last_keep beat=%0d got=%0b/%b exp=1/1111", got, last_m, keep_m);
        end
        got++;
      end
      pv = valid_m; pr = ready_m; pd = data_m; pl = last_m;
      if (!seen_done) @(negedge clk);
      cyc++;
    end
    ready_m = 1'b1;
    checks++; if (!seen_done) begin failures++; $display("FAIL thr_timeout got=no_done exp=done"); end
    checks++; if (got !== 10) begin failures++; $display("FAIL thr_beats got=%0d exp=10", got); end
    checks++; if (pkt_cnt !== 16'd10) begin failures++; $display("FAIL thr_pkt_cnt got=%0d exp=10", pkt_cnt); end
    @(negedge clk);
  endtask

  // Long throttle=3 run at ready=1 to measure the offer rate; burst_len=0 acts as 1.
  task automatic test_rate();
    int beats, cyc, nonlast;
    beats = 0; cyc = 0; nonlast = 0;
    kick(1'b0, 8'd0, 16'd200, 3'd4, 4'd3);
    while (!done && cyc < 4000) begin
      if (valid_m) begin beats++; if (!last_m) nonlast++; end
      @(negedge clk);
      cyc++;
    end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL rate_timeout got=%0b exp=1", done); end
    checks++; if (beats !== 200) begin failures++; $display("FAIL rate_beats got=%0d exp=200", beats); end
    checks++; if (nonlast !== 0) begin failures++; $display("FAIL rate_len0_last got=%0d exp=0", nonlast); end
    checks++; if (cyc < 400 || cyc > 1600) begin failures++; $display("FAIL rate_offer cycles=%0d exp=400..1600", cyc); end
    @(negedge clk);
  endtask

  // LFSR mode, random tail, run twice from the same start.
  task automatic test_lfsr();
    logic [31:0] seq [2][15];
    for (int r = 0; r < 2; r++) begin
      kick(1'b1, 8'd3, 16'd5, 3'd0, 4'd15);
      for (int i = 0; i < 15; i++) begin
        seq[r][i] = data_m;
        checks++; if (valid_m !== 1'b1) begin failures++; $display("FAIL lfsr_valid run=%0d beat=%0d got=0 exp=1", r, i); end
        if (last_m) begin
          checks++; if (!(keep_m == 4'b1000 || keep_m == 4'b1100 || keep_m == 4'b1110 || keep_m == 4'b1111)) begin
            failures++; $display("FAIL lfsr_keep beat=%0d got=%b exp=msb_aligned", i, keep_m);
          end
        end
        if (r == 0 && i == 0) begin
          checks++; if (data_m !== 32'hACE12B3D) begin failures++; $display("FAIL lfsr_beat0 got=%h exp=ace12b3d", data_m); end
        end
        if (r == 0 && i == 1) begin
          checks++; if (data_m !== 32'hD650959D) begin failures++; $display("FAIL lfsr_beat1 got=%h exp=d650959d", data_m); end
        end
        if (r == 0 && i == 2) begin
          checks++; if (data_m !== 32'hEB084ACD || keep_m !== 4'b1100 || last_m !== 1'b1) begin
            failures++; $display("FAIL lfsr_beat2 got=%h/%b/%0b exp=eb084acd/1100/1", data_m, keep_m, last_m);
          end
        end
        @(negedge clk);
      end
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL lfsr_done run=%0d got=%0b exp=1", r, done); end
      @(negedge clk);
    end
    for (int i = 0; i < 15; i++) begin
      checks++; if (seq[1][i] !== seq[0][i]) begin failures++; $display("FAIL lfsr_repeat beat=%0d got=%h exp=%h", i, seq[1][i], seq[0][i]); end
    end
  endtask

  task automatic test_zero_pkts();
    kick(1'b0, 8'd4, 16'd0, 3'd3, 4'd15);
    checks++; if (done !== 1'b0 || valid_m !== 1'b0) begin failures++; $display("FAIL zero_c1 got=%0b/%0b exp=0/0", done, valid_m); end
    @(negedge clk);
    checks++; if (done !== 1'b1 || valid_m !== 1'b0) begin failures++; $display("FAIL zero_c2 got=%0b/%0b exp=1/0", done, valid_m); end
    checks++; if (pkt_cnt !== 16'd0) begin failures++; $display("FAIL zero_pkt_cnt got=%0d exp=0", pkt_cnt); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL zero_c3 got=%0b/%0b exp=0/0", done, busy); end
  endtask

  // Reset on beat 5 of an 8-beat packet, then a fresh run.
  task automatic test_reset_mid();
    bit saw_done;
    saw_done = 0;
    kick(1'b0, 8'd8, 16'd1, 3'd4, 4'd15);
    for (int i = 0; i < 5; i++) @(negedge clk);
    checks++; if (valid_m !== 1'b1 || data_m !== 32'h14151617) begin
      failures++; $display("FAIL rmid_beat5 got=%0b/%h exp=1/14151617", valid_m, data_m);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (valid_m !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%0b exp=0", valid_m); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%0b exp=0", busy); end
    checks++; if (pkt_cnt !== 16'd0) begin failures++; $display("FAIL rmid_pkt_cnt got=%0d exp=0", pkt_cnt); end
    for (int i = 0; i < 4; i++) begin
      if (done) saw_done = 1;
      @(negedge clk);
    end
    checks++; if (saw_done) begin failures++; $display("FAIL rmid_done got=1 exp=0"); end
    test_basic(1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; ready_m = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic(1'b0);
    test_basic(1'b1);
    test_backpressure();
    test_throttle();
    test_rate();
    test_lfsr();
    test_zero_pkts();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
